key_schedule_gen: RTL

//  Parametrised MacGuffin key-schedule engine. Expands a N_PASSES*BLOCK_SIZE-bit key into ROUND_NUM round keys.

---
 rtl/key_schedule_gen.sv | 123 ++++++++++++
 1 files changed

// File: rtl/key_schedule_gen.sv
// MacGuffin key-schedule engine: feeds each key slice through an external cipher
// in OFB feedback and XOR-folds the ciphertext tops into ROUND_NUM round keys.
// Optional macro KS_TLAST_EN adds m_axis_tlast marking the last block of each pass.
module key_schedule_gen #(
    parameter int ROUND_NUM  = 32,
    parameter int BLOCK_SIZE = 64,
    parameter int RK_WIDTH   = 48,
    parameter int N_PASSES   = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic [N_PASSES*BLOCK_SIZE-1:0] key,
    output logic [BLOCK_SIZE-1:0]          m_axis_tdata,
    output logic                           m_axis_tvalid,
`ifdef KS_TLAST_EN
    output logic                           m_axis_tlast,
`endif
    input  logic                           m_axis_tready,
    input  logic [BLOCK_SIZE-1:0]          s_axis_tdata,
    input  logic                           s_axis_tvalid,
    output logic                           s_axis_tready,
    output logic [ROUND_NUM*RK_WIDTH-1:0]  round_keys,
    output logic                           busy,
    output logic                           key_ready
);
    localparam int IW = (ROUND_NUM > 1) ? $clog2(ROUND_NUM) : 1;
    localparam int PW = (N_PASSES > 1) ? $clog2(N_PASSES) : 1;
    localparam logic [IW-1:0] LAST_IDX  = IW'(ROUND_NUM - 1);
    localparam logic [PW-1:0] LAST_PASS = PW'(N_PASSES - 1);

    typedef enum logic [2:0] {IDLE, LOAD, SEND, RECV, DONE} state_t;

    state_t                                  state;
    logic [N_PASSES-1:0][BLOCK_SIZE-1:0]     key_q;
    logic [ROUND_NUM-1:0][RK_WIDTH-1:0]      rk_q;
    logic [BLOCK_SIZE-1:0]                   block;
    logic [IW-1:0]                           idx;
    logic [PW-1:0]                           pass;
    logic [PW-1:0]                           slice_sel;
    logic [RK_WIDTH-1:0]                     rk_new;

    // Pass 0 consumes the most-significant key slice.
    assign slice_sel    = LAST_PASS - pass;
    assign rk_new       = s_axis_tdata[BLOCK_SIZE-1 -: RK_WIDTH];
    assign m_axis_tdata = block;
    assign round_keys   = rk_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            key_q         <= '0;
            block         <= '0;
            idx           <= '0;
            pass          <= '0;
            rk_q          <= '0;
            m_axis_tvalid <= 1'b0;
            s_axis_tready <= 1'b0;
            busy          <= 1'b0;
            key_ready     <= 1'b0;
`ifdef KS_TLAST_EN
            m_axis_tlast  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        key_q     <= key;
                        key_ready <= 1'b0;
                        busy      <= 1'b1;
                        pass      <= '0;
                        idx       <= '0;
                        state     <= LOAD;
                    end
                end
                LOAD: begin
                    block         <= key_q[slice_sel];
                    idx           <= '0;
                    m_axis_tvalid <= 1'b1;
`ifdef KS_TLAST_EN
                    m_axis_tlast  <= (LAST_IDX == '0);
`endif
                    state         <= SEND;
                end
                SEND: begin
                    if (m_axis_tready) begin
                        m_axis_tvalid <= 1'b0;
`ifdef KS_TLAST_EN
                        m_axis_tlast  <= 1'b0;
`endif
                        s_axis_tready <= 1'b1;
                        state         <= RECV;
                    end
                end
                RECV: begin
                    if (s_axis_tvalid && s_axis_tready) begin
                        block         <= s_axis_tdata;
                        rk_q[idx]     <= (pass == '0) ? rk_new : (rk_q[idx] ^ rk_new);
                        s_axis_tready <= 1'b0;
                        if (idx == LAST_IDX) begin
                            if (pass == LAST_PASS) begin
                                busy      <= 1'b0;
                                key_ready <= 1'b1;
                                state     <= DONE;
                            end else begin
                                pass  <= pass + 1'b1;
                                state <= LOAD;
                            end
                        end else begin
                            idx           <= idx + 1'b1;
                            m_axis_tvalid <= 1'b1;
`ifdef KS_TLAST_EN
                            m_axis_tlast  <= (idx + 1'b1 == LAST_IDX);
`endif
                            state         <= SEND;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
